// File: rtl/mux_2x1.sv
// ---------------------------------------------------------------------------
// mux_2x1 -- two-input word-wide multiplexer with a registered copy.
//
// Purpose:
//   salMux is the zero-latency selection (sel ? e2 : e1), intended for
//   datapath use such as ALU operand selection. A registered copy with a
//   valid flag and a select-switch counter is provided for pipelined
//   consumers and debug visibility.
//
// Ports:
//   clk       in   1      system clock, rising edge
//   reset     in   1      synchronous, active-high reset
//   e1        in   WIDTH  data input 0 (sel = 0)
//   e2        in   WIDTH  data input 1 (sel = 1)
//   sel       in   1      select
//   en        in   1      load enable for the registered path
//   salMux    out  WIDTH  combinational mux output
//   salMux_r  out  WIDTH  registered mux output
//   sel_r     out  1      sel captured alongside salMux_r
//   valid_r   out  1      salMux_r was loaded on the previous edge
//   sw_cnt    out  CNT_W  saturating count of sel changes between
//                         consecutive loads
//   par_r     out  1      (only with MUX2X1_PARITY_EN) XOR-reduction of
//                         the value held in salMux_r
//
// Optional feature macro: MUX2X1_PARITY_EN
// ---------------------------------------------------------------------------
module mux_2x1 #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] e1,
    input  logic [WIDTH-1:0] e2,
    input  logic             sel,
    input  logic             en,
    output logic [WIDTH-1:0] salMux,
    output logic [WIDTH-1:0] salMux_r,
    output logic             sel_r,
    output logic             valid_r,
`ifdef MUX2X1_PARITY_EN
    output logic [CNT_W-1:0] sw_cnt,
    output logic             par_r
`else
    output logic [CNT_W-1:0] sw_cnt
`endif
);

    logic [WIDTH-1:0] w_mux;
    logic             w_switch;
    logic             w_cnt_sat;

    logic [WIDTH-1:0] r_data;
    logic             r_sel;
    logic             r_valid;
    logic [CNT_W-1:0] r_sw_cnt;

    // Zero-latency path: never touched by clk, reset or en.
    assign w_mux  = sel ? e2 : e1;
    assign salMux = w_mux;

    // A switch only counts between back-to-back loads; after an idle cycle
    // or reset r_valid is 0, so the first load is never a switch.
    assign w_switch  = en && r_valid && (sel != r_sel);
    assign w_cnt_sat = (r_sw_cnt == {CNT_W{1'b1}});

    always_ff @(posedge clk) begin
        if (reset) begin
            r_data   <= '0;
            r_sel    <= 1'b0;
            r_valid  <= 1'b0;
            r_sw_cnt <= '0;
        end else if (en) begin
            r_data  <= w_mux;
            r_sel   <= sel;
            r_valid <= 1'b1;
            if (w_switch && !w_cnt_sat) begin
                r_sw_cnt <= r_sw_cnt + 1'b1;
            end
        end else begin
            // Data, select and count hold; only the valid flag drops.
            r_valid <= 1'b0;
        end
    end

    assign salMux_r = r_data;
    assign sel_r    = r_sel;
    assign valid_r  = r_valid;
    assign sw_cnt   = r_sw_cnt;

`ifdef MUX2X1_PARITY_EN
    logic r_par;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_par <= 1'b0;
        end else if (en) begin
            r_par <= ^w_mux;
        end
    end

    assign par_r = r_par;
`endif

endmodule

// File: tb/tb_mux_2x1.sv
module tb_mux_2x1;

    localparam int WIDTH = 32;
    localparam int CNT_W = 16;
    localparam int SAT_W = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] e1;
    logic [WIDTH-1:0] e2;
    logic             sel;
    logic             en;
    logic [WIDTH-1:0] salMux;
    logic [WIDTH-1:0] salMux_r;
    logic             sel_r;
    logic             valid_r;
    logic [CNT_W-1:0] sw_cnt;
    logic [WIDTH-1:0] s_salMux;
    logic [WIDTH-1:0] s_salMux_r;
    logic             s_sel_r;
    logic             s_valid_r;
    logic [SAT_W-1:0] s_sw_cnt;
`ifdef MUX2X1_PARITY_EN
    logic             par_r;
    logic             s_par_r;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [WIDTH-1:0] m_q;
    logic             m_sel;
    logic             m_valid;
    int               m_cnt;
    int               m_cnt_sat;
    logic             m_par;

    always #5 clk = ~clk;

    mux_2x1 #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .e1       (e1),
        .e2       (e2),
        .sel      (sel),
        .en       (en),
        .salMux   (salMux),
        .salMux_r (salMux_r),
        .sel_r    (sel_r),
        .valid_r  (valid_r),
`ifdef MUX2X1_PARITY_EN
        .sw_cnt   (sw_cnt),
        .par_r    (par_r)
`else
        .sw_cnt   (sw_cnt)
`endif
    );

    // Narrow counter instance so saturation is reachable in a short run.
    mux_2x1 #(.WIDTH(WIDTH), .CNT_W(SAT_W)) u_sat (
        .clk      (clk),
        .reset    (reset),
        .e1       (e1),
        .e2       (e2),
        .sel      (sel),
        .en       (en),
        .salMux   (s_salMux),
        .salMux_r (s_salMux_r),
        .sel_r    (s_sel_r),
        .valid_r  (s_valid_r),
`ifdef MUX2X1_PARITY_EN
        .sw_cnt   (s_sw_cnt),
        .par_r    (s_par_r)
`else
        .sw_cnt   (s_sw_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive on the falling edge, check the combinational
    // output, advance the model on the rising edge, check registers after it.
    task automatic step(input logic rst_i, input logic en_i, input logic sel_i,
                        input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] chosen;
        @(negedge clk);
        reset = rst_i; en = en_i; sel = sel_i; e1 = a; e2 = b;
        chosen = (sel_i == 1'b0) ? a : b;
        #1;
        chk("salMux", salMux, chosen);
        @(posedge clk);
        if (rst_i) begin
            m_q = '0; m_sel = 1'b0; m_valid = 1'b0; m_cnt = 0; m_cnt_sat = 0; m_par = 1'b0;
        end else if (en_i) begin
            if (m_valid && (sel_i != m_sel)) begin
                if (m_cnt < (2**CNT_W - 1)) m_cnt = m_cnt + 1;
                if (m_cnt_sat < (2**SAT_W - 1)) m_cnt_sat = m_cnt_sat + 1;
            end
            m_q = chosen; m_sel = sel_i; m_valid = 1'b1;
            m_par = ($countones(chosen) % 2) == 1;
        end else begin
            m_valid = 1'b0;
        end
        #1;
        chk("salMux_r", salMux_r, m_q);
        chk("sel_r", sel_r, m_sel);
        chk("valid_r", valid_r, m_valid);
        chk("sw_cnt", sw_cnt, m_cnt);
        chk("sat_sw_cnt", s_sw_cnt, m_cnt_sat);
`ifdef MUX2X1_PARITY_EN
        chk("par_r", par_r, m_par);
`endif
        $display("step rst=%0d en=%0d sel=%0d e1=%08h e2=%08h -> q=%08h sel_r=%0d v=%0d cnt=%0d",
                 rst_i, en_i, sel_i, a, b, salMux_r, sel_r, valid_r, sw_cnt);
    endtask

    initial begin
        logic [WIDTH-1:0] ra, rb;
        logic rr, ren, rs;
        int seq [5] = '{0, 1, 1, 0, 1};

        m_q = '0; m_sel = 1'b0; m_valid = 1'b0; m_cnt = 0; m_cnt_sat = 0; m_par = 1'b0;
        reset = 1'b1; en = 1'b0; sel = 1'b0; e1 = '0; e2 = '0;

        // Combinational path, no clock edge needed
        e1 = 32'h0000_0001; e2 = 32'h0000_0002; sel = 1'b0;
        #1 chk("comb_sel0", salMux, 32'h0000_0001);
        sel = 1'b1;
        #1 chk("comb_sel1", salMux, 32'h0000_0002);

        // Reset, then a registered load
        step(1'b1, 1'b0, 1'b0, 32'h1111_1111, 32'h2222_2222);
        chk("rst_q", salMux_r, 32'h0);
        chk("rst_valid", valid_r, 1'b0);
        step(1'b0, 1'b1, 1'b1, 32'h0, 32'hDEAD_BEEF);
        chk("load_q", salMux_r, 32'hDEAD_BEEF);
        chk("load_sel", sel_r, 1'b1);
        chk("load_valid", valid_r, 1'b1);

        // Hold for three idle cycles with changing inputs
        step(1'b0, 1'b1, 1'b0, 32'hA5A5_A5A5, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, i[0], $urandom, $urandom);
            chk("hold_q", salMux_r, 32'hA5A5_A5A5);
            chk("hold_valid", valid_r, 1'b0);
        end

        // Switch count with sel 0,1,1,0,1 after a reset
        step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, seq[i][0], 32'h1234_5678, 32'h1234_5678);
        chk("sw_cnt_3", sw_cnt, 16'd3);
        chk("equal_inputs", salMux_r, 32'h1234_5678);
        step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("sw_cnt_rst", sw_cnt, 16'd0);
        step(1'b0, 1'b1, 1'b1, 32'hFFFF_0000, 32'h0000_FFFF);
        step(1'b1, 1'b1, 1'b1, 32'hFFFF_0000, 32'h0000_FFFF);
        chk("rst_en_q", salMux_r, 32'h0);
        chk("rst_en_valid", valid_r, 1'b0);
        chk("rst_en_sel", sel_r, 1'b0);

        // Load after idle is not a switch
        step(1'b0, 1'b1, 1'b0, 32'h5, 32'h6);
        step(1'b0, 1'b0, 1'b1, 32'h5, 32'h6);
        step(1'b0, 1'b1, 1'b1, 32'h5, 32'h6);
        chk("idle_no_switch", sw_cnt, 16'd0);

        // Saturation of the narrow counter
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, i[0], $urandom, $urandom);
        chk("sat_cnt_max", s_sw_cnt, 2'd3);

`ifdef MUX2X1_PARITY_EN
        step(1'b0, 1'b1, 1'b0, 32'h0000_0007, 32'h0);
        chk("par_7", par_r, 1'b1);
        step(1'b0, 1'b1, 1'b0, 32'h0000_0003, 32'h0);
        chk("par_3", par_r, 1'b0);
`endif

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            rr  = ($urandom_range(0, 39) == 0);
            ren = ($urandom_range(0, 9) < 7);
            rs  = $urandom_range(0, 1);
            ra  = $urandom;
            rb  = ($urandom_range(0, 7) == 0) ? ra : $urandom;
            step(rr, ren, rs, ra, rb);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_2x1.md
Name: mux_2x1

Overview:
- Two-input, word-wide multiplexer: `e1` when `sel`=0, `e2` when `sel`=1.
- Provides a zero-latency combinational output `salMux` for datapath use, e.g. operand/ALU-source selection in the processor.
- Also provides a registered copy, a valid flag and a select-switch counter for pipelined consumers and debug.
- Single clock domain.

Parameters:
- WIDTH, 32, data width of `e1`, `e2`, `salMux`, `salMux_r`.
- CNT_W, 16, width of the `sw_cnt` select-switch counter.

Ports:
- clk  input  1  system clock; all registers update on rising edge.
- reset  input  1  synchronous, active-high reset.
- e1  input  WIDTH  data input 0, selected when `sel`=0.
- e2  input  WIDTH  data input 1, selected when `sel`=1.
- sel  input  1  select.
- en  input  1  load enable for the registered path.
- salMux  output  WIDTH  combinational mux output.
- salMux_r  output  WIDTH  registered mux output.
- sel_r  output  1  `sel` value captured with `salMux_r`.
- valid_r  output  1  `salMux_r` holds data loaded in the previous cycle.
- sw_cnt  output  CNT_W  count of select changes between consecutive loads.

Behaviour:
- Interface: one clock; reset is synchronous and active-high (ports `clk`, `reset`).
- `salMux = sel ? e2 : e1`, purely combinational.
  - Zero latency; independent of `clk`, `reset`, `en`.
  - X/Z on `sel` is not required to be resolved specially.
- Registered path, evaluated on each rising edge of `clk`:
  - `reset`=1 has priority: `salMux_r`=0, `sel_r`=0, `valid_r`=0, `sw_cnt`=0. `salMux` is unaffected by reset.
  - else `en`=1: `salMux_r` <= `salMux`; `sel_r` <= `sel`; `valid_r` <= 1.
  - else `en`=0: `salMux_r`, `sel_r`, `sw_cnt` hold; `valid_r` <= 0.
  - Latency `e1`/`e2`/`sel` -> `salMux_r`: 1 cycle when `en`=1.
- `sw_cnt` rules:
  - Increments by 1 on an `en`=1 edge where the previously registered load was valid (`valid_r`=1 before the edge) and `sel` != `sel_r`.
  - Saturates at 2^CNT_W-1; never wraps.
  - A load following an idle (`en`=0) cycle or reset does not count as a switch.
- Boundary conditions:
  - Reset asserted mid-stream clears all registered outputs on that edge regardless of `en`.
  - Reset and `en` asserted together: reset wins.
  - `e1`==`e2`: output equals the common value for either `sel`; `sw_cnt` still counts `sel` changes.
  - All registers reach a defined value after one reset edge; no initial blocks are relied upon.

Optional Feature:
- Macro MUX2X1_PARITY_EN.
- Defined:
  - Adds output `par_r` (1 bit) = XOR-reduction of the value loaded into `salMux_r`.
  - Registered on the same edge, same enable.
  - Reset to 0; holds when `en`=0.
- Undefined: `par_r` port and its logic are absent; all other behaviour identical.

Test Plan:
- `e1`=32'h00000001, `e2`=32'h00000002, `sel`=0 -> `salMux`=32'h00000001 within the same timestep, no clock needed.
- Same inputs, `sel`=1 -> `salMux`=32'h00000002 immediately.
- Registered load:
  - Stimulus: `reset` high one edge, then `en`=1, `sel`=1, `e2`=32'hDEADBEEF.
  - Response: after reset edge all registered outputs 0; after next edge `salMux_r`=32'hDEADBEEF, `sel_r`=1, `valid_r`=1.
- Hold:
  - Stimulus: `en`=1 loads 32'hA5A5A5A5, then `en`=0 for 3 cycles while inputs change.
  - Response: `salMux_r` stays 32'hA5A5A5A5, `valid_r`=0 from the first idle edge.
- Switch count:
  - Stimulus: `en`=1 continuously with `sel` sequence 0,1,1,0,1.
  - Response: `sw_cnt`=3; then `reset` -> `sw_cnt`=0; `reset` and `en` both high -> registered outputs 0.
- Parity, MUX2X1_PARITY_EN defined: load 32'h00000007 -> `par_r`=1; load 32'h00000003 -> `par_r`=0.
